// File: rtl/prbs_pkg.sv
// Shared PRBS31 constants, checker state encoding and saturating arithmetic.
package prbs_pkg;

  localparam int PRBS_DATA_W = 64;
  localparam int PRBS_TAP_A  = 31;
  localparam int PRBS_TAP_B  = 28;
  localparam int PRBS_HIST_W = PRBS_TAP_A;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_t;

  // Callers pass max = 2^W-1 for a W-bit counter, so a+b never overflows 64 bits.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] max);
    logic [63:0] sum;
    sum = a + b;
    return (sum > max) ? max : sum;
  endfunction

endpackage

// File: rtl/prbs31_predict64.sv
// Combinational PRBS31 predictor: 31 most recent sequence bits in, next 64 bits out.
// Bit 0 of hist_i is the oldest bit; bit 0 of pred_o is the earliest predicted bit.
module prbs31_predict64
  import prbs_pkg::*;
(
  input  logic [PRBS_HIST_W-1:0] hist_i,
  output logic [PRBS_DATA_W-1:0] pred_o
);

  localparam int SEQ_W = PRBS_HIST_W + PRBS_DATA_W;

  // seq[n] is sequence bit (64k - 31 + n); the recurrence is applied in place.
  function automatic logic [PRBS_DATA_W-1:0] unroll(input logic [PRBS_HIST_W-1:0] h);
    logic [SEQ_W-1:0] seq;
    seq = '0;
    seq[PRBS_HIST_W-1:0] = h;
    for (int n = PRBS_HIST_W; n < SEQ_W; n++) begin
      seq[n] = seq[n-PRBS_TAP_A] ^ seq[n-PRBS_TAP_B];
    end
    return seq[SEQ_W-1:PRBS_HIST_W];
  endfunction

  assign pred_o = unroll(hist_i);

endmodule

// File: rtl/prbs31_rx_checker.sv
// PRBS31 receive checker: self-syncs, locks, counts errored words/bits; results 1 cycle after each valid word.
// No backpressure (rx_valid_i only qualifies words); PRBS31_RX_CHECKER_BITERR_EN adds a popcount stage (bit count lags 1 more cycle).
module prbs31_rx_checker
  import prbs_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int LOCK_GOOD_CNT  = 16,
  parameter int UNLOCK_BAD_CNT = 8,
  parameter int CNT_W          = 32
) (
  input  logic              rx_clk_i,
  input  logic              rx_reset_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  input  logic              clear_i,
  output logic              lock_o,
  output logic              err_word_o,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic [CNT_W-1:0]  err_word_cnt_o,
  output logic [CNT_W-1:0]  err_bit_cnt_o
);

  localparam int          GOOD_W  = $clog2(LOCK_GOOD_CNT + 1);
  localparam int          BAD_W   = $clog2(UNLOCK_BAD_CNT + 1);
  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (DATA_W != PRBS_DATA_W) begin : g_bad_data_w
    $error("prbs31_rx_checker: DATA_W must be 64");
  end
  if (CNT_W < 1 || CNT_W > 63) begin : g_bad_cnt_w
    $error("prbs31_rx_checker: CNT_W must be in 1..63");
  end

  prbs_state_t             state_q, state_d;
  logic [PRBS_HIST_W-1:0]  hist_q, hist_d;
  logic [GOOD_W-1:0]       good_q, good_d;
  logic [BAD_W-1:0]        bad_q, bad_d;
  logic                    lock_q, lock_d;
  logic                    err_word_q, err_word_d;
  logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]        err_word_cnt_q, err_word_cnt_d;

  logic [PRBS_DATA_W-1:0]  expected;
  logic [PRBS_DATA_W-1:0]  diff;
  logic [PRBS_HIST_W-1:0]  seed;
  logic                    word_err;
  logic                    locked_vld;

  prbs31_predict64 u_predict (
    .hist_i (hist_q),
    .pred_o (expected)
  );

  assign diff       = expected ^ rx_data_i;
  assign word_err   = |diff;
  assign seed       = rx_data_i[PRBS_DATA_W-1 -: PRBS_HIST_W];
  assign locked_vld = rx_valid_i && (state_q == LOCKED);

  always_comb begin
    state_d        = state_q;
    hist_d         = hist_q;
    good_d         = good_q;
    bad_d          = bad_q;
    err_word_d     = 1'b0;
    word_cnt_d     = word_cnt_q;
    err_word_cnt_d = err_word_cnt_q;

    if (rx_valid_i) begin
      unique case (state_q)
        HUNT: begin
          // An all-zero seed would lock the generator into the zero sequence.
          if (seed != '0) begin
            hist_d  = seed;
            good_d  = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (word_err) begin
            state_d = HUNT;
          end else begin
            hist_d = seed;
            good_d = good_q + GOOD_W'(1);
            if (good_d == GOOD_W'(LOCK_GOOD_CNT)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end
        end
        LOCKED: begin
          // Free-running reference: received errors never leak into the history.
          hist_d     = expected[PRBS_DATA_W-1 -: PRBS_HIST_W];
          word_cnt_d = CNT_W'(sat_add(64'(word_cnt_q), 64'd1, CNT_MAX));
          if (word_err) begin
            err_word_d     = 1'b1;
            err_word_cnt_d = CNT_W'(sat_add(64'(err_word_cnt_q), 64'd1, CNT_MAX));
            bad_d          = bad_q + BAD_W'(1);
            if (bad_d == BAD_W'(UNLOCK_BAD_CNT)) begin
              state_d = HUNT;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clear_i) begin
      word_cnt_d     = '0;
      err_word_cnt_d = '0;
    end

    lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge rx_clk_i or posedge rx_reset_i) begin
    if (rx_reset_i) begin
      state_q        <= HUNT;
      hist_q         <= '0;
      good_q         <= '0;
      bad_q          <= '0;
      lock_q         <= 1'b0;
      err_word_q     <= 1'b0;
      word_cnt_q     <= '0;
      err_word_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      hist_q         <= hist_d;
      good_q         <= good_d;
      bad_q          <= bad_d;
      lock_q         <= lock_d;
      err_word_q     <= err_word_d;
      word_cnt_q     <= word_cnt_d;
      err_word_cnt_q <= err_word_cnt_d;
    end
  end

  assign lock_o         = lock_q;
  assign err_word_o     = err_word_q;
  assign word_cnt_o     = word_cnt_q;
  assign err_word_cnt_o = err_word_cnt_q;

`ifdef PRBS31_RX_CHECKER_BITERR_EN
  logic [6:0]       pop_q, pop_d;
  logic             pop_vld_q, pop_vld_d;
  logic [CNT_W-1:0] err_bit_cnt_q, err_bit_cnt_d;

  // A clear also drops a popcount still in flight, so all counters read 0 together.
  always_comb begin
    pop_d     = 7'($countones(diff));
    pop_vld_d = locked_vld && !clear_i;
    if (clear_i) begin
      err_bit_cnt_d = '0;
    end else if (pop_vld_q) begin
      err_bit_cnt_d = CNT_W'(sat_add(64'(err_bit_cnt_q), 64'(pop_q), CNT_MAX));
    end else begin
      err_bit_cnt_d = err_bit_cnt_q;
    end
  end

  always_ff @(posedge rx_clk_i or posedge rx_reset_i) begin
    if (rx_reset_i) begin
      pop_q         <= '0;
      pop_vld_q     <= 1'b0;
      err_bit_cnt_q <= '0;
    end else begin
      pop_q         <= pop_d;
      pop_vld_q     <= pop_vld_d;
      err_bit_cnt_q <= err_bit_cnt_d;
    end
  end

  assign err_bit_cnt_o = err_bit_cnt_q;
`else
  logic unused_locked_vld;
  assign unused_locked_vld = locked_vld;
  assign err_bit_cnt_o     = '0;
`endif

endmodule
